cas_fsk_player: RTL and testbench

- Cassette playback transmitter that generates the MSX 1200-baud FSK square wave fed into the core's `cas_audio_in` path.
- An upstream loader supplies a byte stream over a valid/ready handshake, with a flag that marks header-tone requests.
- The block emits the tones and serial frames.
- Transmission advances only while the PPI cassette motor bit is on, so the BIOS read routines see real tape timing.

---
 rtl/cas_fsk_player_pkg.sv | 9 +
 rtl/cas_fsk_player_tone_gen.sv | 49 ++++
 rtl/cas_fsk_player.sv | 94 +++++++++
 tb/tb_cas_fsk_player.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cas_fsk_player_pkg.sv
// cas_fsk_player_pkg: frame states and default MSX cassette FSK timing constants
package cas_fsk_player_pkg;
    typedef enum logic [2:0] {IDLE, HDR, START, DATA, STOP} state_t;
    localparam int HALF_1200 = 1491;
    localparam int HALF_2400 = 746;
    localparam int HDR_LONG  = 16000;
    localparam int HDR_SHORT = 4000;
    localparam int STOP_BITS = 2;
endpackage

// File: rtl/cas_fsk_player_tone_gen.sv
// fsk_tone_gen: half-period timer and square-wave toggle for one FSK bit cell at a time
module fsk_tone_gen #(
    parameter int HALF_1200 = cas_fsk_player_pkg::HALF_1200,
    parameter int HALF_2400 = cas_fsk_player_pkg::HALF_2400
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clk_en,
    input  logic run,
    input  logic bit_val,
    input  logic start,
    output logic audio,
    output logic bit_done,
    output logic cycle_done
);
    localparam logic [10:0] LAST_0 = 11'(HALF_1200 - 1);
    localparam logic [10:0] LAST_1 = 11'(HALF_2400 - 1);

    logic [10:0] cnt;
    logic [1:0]  halves;
    logic        tick;
    logic        half_done;
    logic        last_half;

    assign tick       = clk_en && run;
    assign half_done  = tick && (cnt == (bit_val ? LAST_1 : LAST_0));
    assign last_half  = halves == (bit_val ? 2'd3 : 2'd1);
    assign bit_done   = half_done && last_half;
    assign cycle_done = half_done && halves[0];

    // A new item drives the line high; each expired half period flips it and advances the cell count
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt    <= '0;
            halves <= '0;
            audio  <= 1'b0;
        end else if (start) begin
            cnt    <= '0;
            halves <= '0;
            audio  <= 1'b1;
        end else if (tick) begin
            cnt <= half_done ? 11'd0 : cnt + 11'd1;
            if (half_done) begin
                halves <= last_half ? 2'd0 : halves + 2'd1;
                audio  <= ~audio;
            end
        end
    end
endmodule

// File: rtl/cas_fsk_player.sv
// cas_fsk_player: MSX 1200-baud cassette FSK transmitter fed by a valid/ready byte/header stream
module cas_fsk_player #(
    parameter int HALF_1200 = cas_fsk_player_pkg::HALF_1200,
    parameter int HALF_2400 = cas_fsk_player_pkg::HALF_2400,
    parameter int HDR_LONG  = cas_fsk_player_pkg::HDR_LONG,
    parameter int HDR_SHORT = cas_fsk_player_pkg::HDR_SHORT,
    parameter int STOP_BITS = cas_fsk_player_pkg::STOP_BITS
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       clk_en_i,
    input  logic       motor_i,
    input  logic [7:0] data_i,
    input  logic       hdr_i,
    input  logic       long_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       audio_o,
    output logic       busy_o
);
    import cas_fsk_player_pkg::*;

    localparam logic [14:0] N_LONG  = 15'(HDR_LONG - 1);
    localparam logic [14:0] N_SHORT = 15'(HDR_SHORT - 1);
    localparam logic [3:0]  N_STOP  = 4'(STOP_BITS - 1);

    state_t      state;
    state_t      nxt;
    logic [7:0]  data_q;
    logic        long_q;
    logic [2:0]  idx;
    logic [3:0]  stop_cnt;
    logic [14:0] hdr_cnt;
    logic        accept;
    logic        run;
    logic        bit_val;
    logic        bit_done;
    logic        cycle_done;

    assign ready_o = (state == IDLE) && motor_i;
    assign busy_o  = state != IDLE;
    assign accept  = valid_i && ready_o;
    assign run     = motor_i && busy_o;
    assign bit_val = (state == HDR) || (state == STOP) || ((state == DATA) && data_q[idx]);

    fsk_tone_gen #(
        .HALF_1200(HALF_1200),
        .HALF_2400(HALF_2400)
    ) u_tone (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clk_en    (clk_en_i),
        .run       (run),
        .bit_val   (bit_val),
        .start     (accept),
        .audio     (audio_o),
        .bit_done  (bit_done),
        .cycle_done(cycle_done)
    );

    // Frame sequencing: leave IDLE on acceptance, return on the tick that ends the last half period
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? (hdr_i ? HDR : START) : IDLE;
            HDR:     nxt = (cycle_done && hdr_cnt == (long_q ? N_LONG : N_SHORT)) ? IDLE : HDR;
            START:   nxt = bit_done ? DATA : START;
            DATA:    nxt = (bit_done && idx == 3'd7) ? STOP : DATA;
            STOP:    nxt = (bit_done && stop_cnt == N_STOP) ? IDLE : STOP;
            default: nxt = IDLE;
        endcase
    end

    // State, latched item and position counters; everything else stalls while the motor is off
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= IDLE;
            data_q   <= '0;
            long_q   <= 1'b0;
            idx      <= '0;
            stop_cnt <= '0;
            hdr_cnt  <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                data_q <= data_i;
                long_q <= long_i;
            end
            if (state == DATA && bit_done) idx <= idx + 3'd1;
            if (state == STOP && bit_done) stop_cnt <= (stop_cnt == N_STOP) ? 4'd0 : stop_cnt + 4'd1;
            if (state == HDR && cycle_done) hdr_cnt <= (nxt == IDLE) ? 15'd0 : hdr_cnt + 15'd1;
        end
    end
endmodule

// File: tb/tb_cas_fsk_player.sv
// tb_cas_fsk_player: table-driven and randomized waveform checks of the cassette FSK player
`timescale 1ns/1ps
module tb_cas_fsk_player;
    localparam int H0 = 5;
    localparam int H1 = 3;
    localparam int HL = 12;
    localparam int HS = 5;
    localparam int SB = 2;

    typedef struct {
        bit         h;
        bit         l;
        logic [7:0] d;
        bit         rmot;
        int         tog;
    } vec_t;

    logic       clk_i = 0;
    logic       reset_n_i = 0;
    logic       clk_en_i = 0;
    logic       motor_i = 0;
    logic [7:0] data_i = 0;
    logic       hdr_i = 0;
    logic       long_i = 0;
    logic       valid_i = 0;
    logic       ready_o;
    logic       audio_o;
    logic       busy_o;

    int errors = 0;
    int checks = 0;
    bit last_tick;
    int exp_w[$];

    cas_fsk_player #(
        .HALF_1200(H0),
        .HALF_2400(H1),
        .HDR_LONG (HL),
        .HDR_SHORT(HS),
        .STOP_BITS(SB)
    ) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .clk_en_i (clk_en_i),
        .motor_i  (motor_i),
        .data_i   (data_i),
        .hdr_i    (hdr_i),
        .long_i   (long_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .audio_o  (audio_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic step();
        last_tick = clk_en_i && motor_i;
        @(posedge clk_i);
        #1;
    endtask

    // Expected half-period widths (in motor-on ticks) of one item, straight from the bit encoding
    function automatic void model(input bit h, input bit l, input logic [7:0] d);
        bit cells[$];
        exp_w = {};
        if (h) begin
            repeat (2 * (l ? HL : HS)) exp_w.push_back(H1);
            return;
        end
        cells.push_back(1'b0);
        for (int i = 0; i < 8; i++) cells.push_back(d[i]);
        repeat (SB) cells.push_back(1'b1);
        foreach (cells[i]) repeat (cells[i] ? 4 : 2) exp_w.push_back(cells[i] ? H1 : H0);
    endfunction

    // Recover a frame from measured widths: bit k of the result is frame cell k, -1 if malformed
    function automatic int decode(input int w[$]);
        int i = 0;
        int k = 0;
        int f = 0;
        while (i < w.size()) begin
            if (i + 1 < w.size() && w[i] == H0 && w[i+1] == H0) i += 2;
            else if (i + 3 < w.size() && w[i] == H1 && w[i+1] == H1 && w[i+2] == H1 && w[i+3] == H1) begin
                f |= 1 << k;
                i += 4;
            end else return -1;
            k++;
        end
        return (k == 9 + SB) ? f : -1;
    endfunction

    task automatic send(input bit h, input bit l, input logic [7:0] d, input bit rmot, input int exp_tog);
        int got[$];
        int ticks = 0;
        int n = 0;
        int moff = 0;
        int bad = 0;
        bit pa = 1;
        bit done = 0;
        bit frozen_ok = 1;
        bit rdy_ok = 1;
        bit end_ok = 0;
        model(h, l, d);
        valid_i = 1; hdr_i = h; long_i = l; data_i = d; motor_i = 1;
        clk_en_i = 1'($urandom_range(0, 1));
        #1 check("ready_idle", ready_o, 1);
        step();
        valid_i = 0; hdr_i = 1'($urandom_range(0, 1)); long_i = 1'($urandom_range(0, 1)); data_i = 8'($urandom);
        check("start_level", {audio_o, busy_o}, 3);
        while (!done && n < 5000) begin
            clk_en_i = ($urandom_range(0, 3) != 0);
            if (rmot && moff == 0 && $urandom_range(0, 29) == 0) moff = $urandom_range(3, 40);
            motor_i = (moff == 0);
            if (moff > 0) moff--;
            step();
            n++;
            if (last_tick) ticks++;
            if (!motor_i && ready_o) rdy_ok = 0;
            if (audio_o != pa) begin
                if (!last_tick) frozen_ok = 0;
                got.push_back(ticks);
                ticks = 0;
                pa = audio_o;
                if (!busy_o) end_ok = 1;
            end
            if (!busy_o) done = 1;
        end
        check("item_done", done, 1);
        check("ready_after", ready_o, 1);
        motor_i = 1;
        if (exp_tog >= 0) check("toggles", got.size(), exp_tog);
        check("model_len", got.size(), exp_w.size());
        for (int i = 0; i < got.size() && i < exp_w.size(); i++) if (got[i] != exp_w[i]) bad++;
        check("width_errs", bad, 0);
        check("frozen_audio", frozen_ok, 1);
        check("ready_motor", rdy_ok, 1);
        check("idle_on_last_edge", end_ok, 1);
        if (!h) check("frame", decode(got), (((1 << SB) - 1) << 9) | (int'(d) << 1));
    endtask

    task automatic back_to_back();
        logic [7:0] b[3];
        int acc = 0;
        int busy_n = 0;
        int idle_n = 0;
        int n = 0;
        int exp_busy = 0;
        b[0] = 8'h5A; b[1] = 8'h00; b[2] = 8'hF1;
        for (int k = 0; k < 3; k++) begin
            model(0, 0, b[k]);
            foreach (exp_w[i]) exp_busy += exp_w[i];
        end
        clk_en_i = 1; motor_i = 1; valid_i = 1; hdr_i = 0; data_i = b[0];
        #1;
        while (n < 3000 && (acc < 3 || busy_o)) begin
            if (ready_o && valid_i) acc++;
            step();
            n++;
            if (busy_o) busy_n++;
            else if (acc < 3) idle_n++;
            valid_i = acc < 3;
            if (acc < 3) data_i = b[acc];
        end
        check("b2b_accepts", acc, 3);
        check("b2b_idle_cycles", idle_n, 2);
        check("b2b_busy_cycles", busy_n, exp_busy);
    endtask

    task automatic reset_mid_data();
        valid_i = 1; hdr_i = 0; data_i = 8'hC3; motor_i = 1; clk_en_i = 1;
        step();
        valid_i = 0;
        repeat (2 * H0 + 1) step();
        check("pre_reset_state", {audio_o, busy_o}, 3);
        #2 reset_n_i = 0;
        #1 check("reset_async", {audio_o, busy_o}, 0);
        step();
        reset_n_i = 1;
        step();
        send(0, 0, 8'h3C, 0, 34);
    endtask

    initial begin
        vec_t tbl[6];
        tbl = '{
            '{0, 0, 8'h00, 0, 26},
            '{0, 0, 8'hA5, 0, 34},
            '{1, 0, 8'h00, 0, 10},
            '{1, 1, 8'h00, 0, 24},
            '{0, 0, 8'hFF, 1, 42},
            '{0, 0, 8'h5A, 1, 34}
        };
        repeat (3) step();
        check("reset_outputs", {audio_o, busy_o, ready_o}, 0);
        reset_n_i = 1;
        step();
        check("ready_motor_off", ready_o, 0);
        motor_i = 1;
        #1 check("ready_motor_on", ready_o, 1);
        foreach (tbl[i]) send(tbl[i].h, tbl[i].l, tbl[i].d, tbl[i].rmot, tbl[i].tog);
        for (int i = 0; i < 8; i++)
            send($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 8'($urandom), 1, -1);
        back_to_back();
        reset_mid_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
